// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_INCR         = 32'd4;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-pc selection: exception > redirect > sequential, no latency, no state.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = PC_EXC_VECTOR
) (
    input  logic [31:0] pc,
    input  logic        exc_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        take_redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] seq_pc
);

    always_comb begin
        take_redirect = exc_req | redirect_valid;
        redirect_pc   = redirect_target & 32'hFFFF_FFFC;
        if (exc_req) begin
            redirect_pc = EXC_VECTOR;
        end
    end

    assign seq_pc = pc + PC_INCR;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch PC sequencer; ack-to-if_valid latency 1, stall holds the presented word.
// Optional exception entry (exc_req/epc) compiled in with PC_SEQ_EXC_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = PC_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
`ifdef PC_SEQ_EXC_EN
    input  logic        exc_req,
    output logic [31:0] epc,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

`ifndef PC_SEQ_EXC_EN
    logic exc_req;
    assign exc_req = 1'b0;
`endif

    pc_state_t   state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        squash, squash_nxt;
    logic [31:0] squash_pc, squash_pc_nxt;
    logic        capture;
    logic        take_redirect;
    logic [31:0] redirect_pc, seq_pc;

    pc_next_sel #(.EXC_VECTOR(EXC_VECTOR)) u_next_sel (
        .pc              (pc),
        .exc_req         (exc_req),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .take_redirect   (take_redirect),
        .redirect_pc     (redirect_pc),
        .seq_pc          (seq_pc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= RESET_VECTOR;
            squash    <= 1'b0;
            squash_pc <= '0;
            if_instr  <= '0;
            if_pc     <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            squash    <= squash_nxt;
            squash_pc <= squash_pc_nxt;
            if (capture) begin
                if_instr <= imem_rdata;
                if_pc    <= pc;
            end
        end
    end

    // pc must stay put while a request is outstanding, so a redirect during REQ
    // is parked in squash_pc and applied when the pending ack retires.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        squash_nxt    = squash;
        squash_pc_nxt = squash_pc;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (take_redirect) pc_nxt = redirect_pc;
            end
            REQ: begin
                if (imem_ack) begin
                    squash_nxt = 1'b0;
                    if (take_redirect) begin
                        pc_nxt = redirect_pc;
                    end else if (squash) begin
                        pc_nxt = squash_pc;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = VALID;
                    end
                end else if (take_redirect) begin
                    squash_nxt    = 1'b1;
                    squash_pc_nxt = redirect_pc;
                end
            end
            VALID: begin
                if (take_redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = REQ;
                end else if (!stall) begin
                    pc_nxt    = seq_pc;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign if_valid  = (state == VALID);

`ifdef PC_SEQ_EXC_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            epc <= '0;
        end else if (exc_req) begin
            epc <= (state == VALID) ? if_pc : pc;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: transaction-level fetch model checked every cycle plus directed literal checks.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, imem_ack, exc;
    logic [31:0] redirect_target, imem_rdata;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_instr, if_pc;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc;
`ifdef PC_SEQ_EXC_EN
    logic [31:0] epc, w_epc;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
`ifdef PC_SEQ_EXC_EN
        .exc_req         (exc),
        .epc             (epc),
`endif
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc)
    );

    // Second instance starting at the top of the address space, always acked.
    pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC), .EXC_VECTOR(EV)) dut_wrap (
        .clk             (clk),
        .reset           (reset),
        .stall           (1'b0),
        .redirect_valid  (1'b0),
        .redirect_target (32'h0),
`ifdef PC_SEQ_EXC_EN
        .exc_req         (1'b0),
        .epc             (w_epc),
`endif
        .imem_req        (w_req),
        .imem_addr       (w_addr),
        .imem_ack        (1'b1),
        .imem_rdata      (32'h1234_5678),
        .if_valid        (w_valid),
        .if_instr        (w_instr),
        .if_pc           (w_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h8) ? 32'h2402_0005 : {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: phase 0 = waiting after reset, 1 = fetch outstanding, 2 = word presented.
    int          ph;
    logic [31:0] m_pc, m_ipc, m_instr, m_epc, dest;
    logic [31:0] pend[$];
    logic        go;

    always @(posedge clk) begin
        go   = redirect_valid | exc;
        dest = exc ? EV : {redirect_target[31:2], 2'b00};
        if (!reset) begin
            ph = 0; m_pc = RV; m_ipc = 0; m_instr = 0; m_epc = 0;
            pend.delete();
        end else begin
            if (exc) m_epc = (ph == 2) ? m_ipc : m_pc;
            if (ph == 0) begin
                if (go) m_pc = dest;
                ph = 1;
            end else if (ph == 1) begin
                if (imem_ack) begin
                    if (go) m_pc = dest;
                    else if (pend.size() > 0) m_pc = pend[$];
                    else begin
                        m_instr = mem_word(m_pc);
                        m_ipc   = m_pc;
                        ph      = 2;
                    end
                    pend.delete();
                end else if (go) begin
                    pend.push_back(dest);
                end
            end else begin
                if (go) begin
                    m_pc = dest; ph = 1;
                end else if (!stall) begin
                    m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000); ph = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req",   32'(imem_req), 32'(ph == 1));
            chk("m_addr",  imem_addr, m_pc);
            chk("m_valid", 32'(if_valid), 32'(ph == 2));
            chk("m_instr", if_instr, m_instr);
            chk("m_ifpc",  if_pc, m_ipc);
`ifdef PC_SEQ_EXC_EN
            chk("m_epc",   epc, m_epc);
`endif
        end
    end

    task automatic step(input logic a, input logic s, input logic r, input logic [31:0] t);
        imem_ack        = a;
        stall           = s;
        redirect_valid  = r;
        redirect_target = t;
        imem_rdata      = mem_word(imem_addr);
        @(negedge clk);
    endtask

    initial begin
        reset = 0; stall = 0; redirect_valid = 0; redirect_target = 0;
        imem_ack = 0; imem_rdata = 0; exc = 0;
        @(negedge clk);
        step(0, 0, 0, 0);
        chk_en = 1'b1;
        step(1, 0, 0, 0);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, RV);
        chk("rst_valid", 32'(if_valid), 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_ifpc", if_pc, 0);

        reset = 1;
        step(0, 0, 0, 0);
        chk("f0_req", 32'(imem_req), 1);
        chk("f0_addr", imem_addr, 32'h0);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        chk("f0_valid", 32'(if_valid), 1);
        chk("f0_ifpc", if_pc, 32'h0);
        chk("f0_instr", if_instr, 32'h0000_FFFF);
        chk("wrap_ifpc", w_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("f1_addr", imem_addr, 32'h4);
        chk("wrap_req1", 32'(w_req), 1);
        chk("wrap_addr1", w_addr, 32'h0);
        step(1, 0, 0, 0);
        chk("f1_ifpc", if_pc, 32'h4);
        step(0, 0, 0, 0);
        chk("f2_addr", imem_addr, 32'h8);
        step(1, 0, 0, 0);
        chk("f2_instr", if_instr, 32'h2402_0005);

        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            chk("stall_req", 32'(imem_req), 0);
            chk("stall_instr", if_instr, 32'h2402_0005);
            chk("stall_ifpc", if_pc, 32'h8);
        end
        step(0, 0, 0, 0);
        chk("post_stall_addr", imem_addr, 32'hC);
        step(0, 0, 0, 0);
        chk("hold_addr", imem_addr, 32'hC);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("f4_addr", imem_addr, 32'h10);

        step(1, 0, 1, 32'h0000_0103);
        chk("redir_ack_addr", imem_addr, 32'h100);
        chk("redir_ack_valid", 32'(if_valid), 0);
        step(0, 0, 1, 32'h200);
        chk("squash_hold", imem_addr, 32'h100);
        step(0, 0, 1, 32'h307);
        step(1, 0, 0, 0);
        chk("squash_last_addr", imem_addr, 32'h304);
        chk("squash_valid", 32'(if_valid), 0);
        step(1, 0, 0, 0);
        chk("squash_ifpc", if_pc, 32'h304);
        step(0, 1, 1, 32'h40);
        chk("vredir_addr", imem_addr, 32'h40);
        chk("vredir_valid", 32'(if_valid), 0);
        step(1, 0, 0, 0);
        chk("f40_ifpc", if_pc, 32'h40);

`ifdef PC_SEQ_EXC_EN
        exc = 1;
        step(0, 0, 1, 32'h500);
        exc = 0;
        chk("exc_addr", imem_addr, 32'h8000_0180);
        chk("exc_epc", epc, 32'h40);
`endif

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("pend_req", 32'(imem_req), 1);
        reset = 0;
        step(0, 0, 0, 0);
        chk("midrst_req", 32'(imem_req), 0);
        chk("midrst_addr", imem_addr, RV);
        reset = 1;
        step(0, 0, 0, 0);
        chk("refetch_addr", imem_addr, RV);
        chk("refetch_req", 32'(imem_req), 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("tail_ifpc", if_pc, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
